// File: rtl/datamemory_stage_hs.sv
// MEM-stage load/store unit: builds byte-lane store requests, aligns and extends load data,
// and stalls the pipeline across a valid/ready request and response handshake.
module datamemory_stage_hs #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic                op_load,
    input  logic                op_store,
    input  logic [1:0]          op_size,
    input  logic                op_unsigned,
    input  logic                op_pc4sel,
    input  logic [XLEN-1:0]     alu_y,
    input  logic [XLEN-1:0]     rrd2,
    input  logic [XLEN-1:0]     pc_4,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_a,
    output logic [XLEN-1:0]     mem_wd,
    output logic [XLEN/8-1:0]   mem_wmask,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_err,
    output logic                stall,
    output logic [XLEN-1:0]     dataout,
    output logic                exc_misalign,
    output logic                exc_bus
);

    localparam int LANES = XLEN / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [XLEN-1:0]    cap_r;
    logic               err_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [OFFW-1:0]    off_s;
    logic               is_mem_s;
    logic               is_load_s;
    logic               misalign_s;
    logic               start_s;
    logic               timeout_s;
    logic [XLEN-1:0]    resp_val_s;
    logic [XLEN-1:0]    abort_val_s;

    // Shift the addressed lane down, then mask and sign/zero-extend to the access width.
    function automatic logic [XLEN-1:0] load_ext(
        input logic [XLEN-1:0] rd,
        input logic [OFFW-1:0] o,
        input logic [1:0]      sz,
        input logic            uns
    );
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] m;
        logic            sb;
        sh = rd >> {o, 3'b000};
        case (sz)
            2'd0:    begin m = XLEN'(8'hFF);         sb = sh[7];  end
            2'd1:    begin m = XLEN'(16'hFFFF);      sb = sh[15]; end
            2'd2:    begin m = XLEN'(32'hFFFF_FFFF); sb = sh[31]; end
            default: begin m = {XLEN{1'b1}};         sb = 1'b0;   end
        endcase
        load_ext = (sh & m) | ((sb & ~uns) ? ~m : {XLEN{1'b0}});
    endfunction

    // Operation decode, alignment check and store lane formatting.
    always_comb begin
        off_s     = alu_y[OFFW-1:0];
        is_mem_s  = op_load | op_store;
        is_load_s = op_load;
        mem_a     = {alu_y[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        case (op_size)
            2'd0: begin
                misalign_s = 1'b0;
                mem_wmask  = LANES'(1'b1) << off_s;
                mem_wd     = {LANES{rrd2[7:0]}};
            end
            2'd1: begin
                misalign_s = off_s[0];
                mem_wmask  = LANES'(2'b11) << off_s;
                mem_wd     = {(LANES/2){rrd2[15:0]}};
            end
            2'd2: begin
                misalign_s = (off_s[1:0] != 2'b00);
                mem_wmask  = LANES'(4'hF) << off_s;
                mem_wd     = {(LANES/4){rrd2[31:0]}};
            end
            default: begin
                // Doubleword only exists on a 64-bit datapath.
                misalign_s = (XLEN == 32) || (off_s != {OFFW{1'b0}});
                mem_wmask  = {LANES{1'b1}};
                mem_wd     = rrd2;
            end
        endcase
    end

    // Handshake outputs; a fresh aligned access requests in the cycle it is presented.
    always_comb begin
        start_s      = (state_r == IDLE) && op_valid && is_mem_s && !misalign_s && !reset;
        mem_valid    = start_s || (state_r == REQ);
        mem_we       = mem_valid && op_store && !op_load;
        stall        = start_s || (state_r == REQ) || (state_r == WAIT);
        exc_misalign = (state_r == IDLE) && op_valid && is_mem_s && misalign_s && !reset;
        exc_bus      = (state_r == DONE) && err_r;
        timeout_s    = (TIMEOUT != 0) && (cnt_r == TO_CNT);
        resp_val_s   = is_load_s ? load_ext(mem_rdata, off_s, op_size, op_unsigned) : alu_y;
        abort_val_s  = is_load_s ? {XLEN{1'b0}} : alu_y;
        if (state_r == DONE) begin
            dataout = cap_r;
        end else if (is_mem_s || !op_pc4sel) begin
            dataout = alu_y;
        end else begin
            dataout = pc_4;
        end
    end

    // Access FSM with response capture and timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cap_r   <= {XLEN{1'b0}};
            err_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    err_r <= 1'b0;
                    cnt_r <= {CNT_W{1'b0}};
                    if (start_s) begin
                        // The presentation cycle already counts toward the timeout.
                        cnt_r <= CNT_W'(1'b1);
                        if (mem_ready && mem_rvalid) begin
                            cap_r   <= resp_val_s;
                            err_r   <= mem_err;
                            state_r <= DONE;
                        end else if (mem_ready) begin
                            state_r <= WAIT;
                        end else begin
                            state_r <= REQ;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                    if (mem_ready && mem_rvalid) begin
                        cap_r   <= resp_val_s;
                        err_r   <= mem_err;
                        state_r <= DONE;
                    end else if (timeout_s) begin
                        cap_r   <= abort_val_s;
                        err_r   <= 1'b1;
                        state_r <= DONE;
                    end else if (mem_ready) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                    if (mem_rvalid) begin
                        cap_r   <= resp_val_s;
                        err_r   <= mem_err;
                        state_r <= DONE;
                    end else if (timeout_s) begin
                        cap_r   <= abort_val_s;
                        err_r   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DONE: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datamemory_stage_hs.sv
// Scoreboard bench for datamemory_stage_hs: a 32-bit instance (short timeout) and a
// 64-bit instance share stimulus; sel routes op_valid and observation to one of them.
module tb_datamemory_stage_hs;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        op_valid, op_load, op_store, op_unsigned, op_pc4sel;
    logic [1:0]  op_size;
    logic [63:0] alu_y, rrd2, pc_4, mem_rdata;
    logic        mem_ready, mem_rvalid, mem_err;

    logic        mv32, we32, st32, em32, eb32;
    logic [31:0] a32, wd32, do32;
    logic [3:0]  wm32;
    logic        mv64, we64, st64, em64, eb64;
    logic [31:0] a64;
    logic [63:0] wd64, do64;
    logic [7:0]  wm64;

    logic        ov32, ov64;
    assign ov32 = op_valid & ~sel;
    assign ov64 = op_valid & sel;

    always #5 clk = ~clk;

    datamemory_stage_hs #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .reset(reset), .op_valid(ov32), .op_load(op_load), .op_store(op_store),
        .op_size(op_size), .op_unsigned(op_unsigned), .op_pc4sel(op_pc4sel),
        .alu_y(alu_y[31:0]), .rrd2(rrd2[31:0]), .pc_4(pc_4[31:0]),
        .mem_valid(mv32), .mem_ready(mem_ready), .mem_we(we32), .mem_a(a32), .mem_wd(wd32),
        .mem_wmask(wm32), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]), .mem_err(mem_err),
        .stall(st32), .dataout(do32), .exc_misalign(em32), .exc_bus(eb32)
    );

    datamemory_stage_hs #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) dut64 (
        .clk(clk), .reset(reset), .op_valid(ov64), .op_load(op_load), .op_store(op_store),
        .op_size(op_size), .op_unsigned(op_unsigned), .op_pc4sel(op_pc4sel),
        .alu_y(alu_y), .rrd2(rrd2), .pc_4(pc_4),
        .mem_valid(mv64), .mem_ready(mem_ready), .mem_we(we64), .mem_a(a64), .mem_wd(wd64),
        .mem_wmask(wm64), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .stall(st64), .dataout(do64), .exc_misalign(em64), .exc_bus(eb64)
    );

    logic        mv_m, we_m, st_m, em_m, eb_m;
    logic [31:0] a_m;
    logic [63:0] wd_m, do_m;
    logic [7:0]  wm_m;
    assign mv_m = sel ? mv64 : mv32;
    assign we_m = sel ? we64 : we32;
    assign st_m = sel ? st64 : st32;
    assign em_m = sel ? em64 : em32;
    assign eb_m = sel ? eb64 : eb32;
    assign a_m  = sel ? a64  : a32;
    assign wd_m = sel ? wd64 : {32'h0, wd32};
    assign do_m = sel ? do64 : {32'h0, do32};
    assign wm_m = sel ? wm64 : {4'h0, wm32};

    typedef struct {
        string       nm;
        logic [63:0] d;
        logic        bus;
        logic        mis;
    } res_t;
    typedef struct {
        string       nm;
        logic        we;
        logic [31:0] a;
        logic [63:0] wd;
        logic [7:0]  mask;
    } req_t;

    res_t res_q[$];
    req_t req_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations when a request is accepted or an op completes.
    always @(negedge clk) begin
        if (!reset) begin
            if (mv_m && mem_ready) begin
                if (req_q.size() == 0) begin
                    chk("unexpected request", {32'h0, a_m}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk({r.nm, " we"}, {63'h0, we_m}, {63'h0, r.we});
                    chk({r.nm, " addr"}, {32'h0, a_m}, {32'h0, r.a});
                    chk({r.nm, " wmask"}, {56'h0, wm_m}, {56'h0, r.mask});
                    chk({r.nm, " wdata"}, wd_m, r.wd);
                end
            end
            if (op_valid && !st_m) begin
                if (res_q.size() == 0) begin
                    chk("unexpected completion", do_m, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    res_t e;
                    e = res_q.pop_front();
                    chk({e.nm, " dataout"}, do_m, e.d);
                    chk({e.nm, " exc_bus"}, {63'h0, eb_m}, {63'h0, e.bus});
                    chk({e.nm, " exc_misalign"}, {63'h0, em_m}, {63'h0, e.mis});
                end
            end
        end
    end

    // Present one op and play the memory side: ready after rlat cycles (-1 never),
    // response rvlat cycles after acceptance (-1 never). Starts and ends at posedge+1.
    task automatic run(input string nm, input logic ld, input logic st, input logic [1:0] sz,
                       input logic un, input logic pc4s, input logic [63:0] a,
                       input logic [63:0] wdat, input logic [63:0] pc,
                       input int rlat, input int rvlat, input logic [63:0] rdat, input logic err,
                       input int exp_stall, input logic [63:0] exp_out, input logic exp_bus,
                       input logic exp_mis, input logic exp_req, input logic [63:0] exp_wd,
                       input logic [7:0] exp_mask);
        int c;
        int acc;
        bit done;
        res_t e;
        req_t r;
        e.nm = nm; e.d = exp_out; e.bus = exp_bus; e.mis = exp_mis;
        res_q.push_back(e);
        if (exp_req) begin
            r.nm = nm; r.we = st & ~ld; r.wd = exp_wd; r.mask = exp_mask;
            r.a = a[31:0] & (sel ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC);
            req_q.push_back(r);
        end
        op_valid = 1'b1; op_load = ld; op_store = st; op_size = sz;
        op_unsigned = un; op_pc4sel = pc4s; alu_y = a; rrd2 = wdat; pc_4 = pc;
        c = 0; acc = -1; done = 0;
        while (!done) begin
            mem_ready  = (rlat >= 0) && (c >= rlat);
            mem_rvalid = (acc >= 0) && (rvlat >= 0) && (c == acc + rvlat);
            mem_rdata  = rdat;
            mem_err    = err;
            @(negedge clk);
            if (mv_m && mem_ready && acc < 0) acc = c;
            if (!st_m) begin
                done = 1;
            end else begin
                c++;
                if (c > 40) begin
                    chk({nm, " stall bound"}, 64'(c), 64'(exp_stall));
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        chk({nm, " stall cycles"}, 64'(c), 64'(exp_stall));
        op_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sel = 1'b0; op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
        op_size = 2'd0; op_unsigned = 1'b0; op_pc4sel = 1'b0; alu_y = 64'h0; rrd2 = 64'h0;
        pc_4 = 64'h0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0; mem_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {56'h0, mv32, st32, em32, eb32, mv64, st64, em64, eb64}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // 32-bit datapath
        run("LW 0x100", 1, 0, 2'd2, 0, 0, 64'h100, 64'h0, 64'h0, 0, 2, 64'hDEAD_BEEF, 0,
            3, 64'hDEAD_BEEF, 0, 0, 1, 64'h0, 8'h0F);
        run("LB 0x103", 1, 0, 2'd0, 0, 0, 64'h103, 64'h0, 64'h0, 1, 1, 64'h80FF_0000, 0,
            3, 64'hFFFF_FF80, 0, 0, 1, 64'h0, 8'h08);
        run("LBU 0x102", 1, 0, 2'd0, 1, 0, 64'h102, 64'h0, 64'h0, 0, 1, 64'h80FF_0000, 0,
            2, 64'h0000_00FF, 0, 0, 1, 64'h0, 8'h04);
        run("LH 0x102", 1, 0, 2'd1, 0, 0, 64'h102, 64'h0, 64'h0, 0, 1, 64'h80FF_0000, 0,
            2, 64'hFFFF_80FF, 0, 0, 1, 64'h0, 8'h0C);
        run("LHU 0x100", 1, 0, 2'd1, 1, 0, 64'h100, 64'h0, 64'h0, 0, 1, 64'h1234_F00D, 0,
            2, 64'h0000_F00D, 0, 0, 1, 64'h0, 8'h03);
        run("SH 0x102", 0, 1, 2'd1, 0, 0, 64'h102, 64'h1234_ABCD, 64'h0, 0, 1, 64'h0, 0,
            2, 64'h102, 0, 0, 1, 64'hABCD_ABCD, 8'h0C);
        run("SB 0x101", 0, 1, 2'd0, 0, 0, 64'h101, 64'hCAFE_0177, 64'h0, 2, 1, 64'h0, 0,
            4, 64'h101, 0, 0, 1, 64'h7777_7777, 8'h02);
        run("SW err 0x104", 0, 1, 2'd2, 0, 0, 64'h104, 64'h0102_0304, 64'h0, 0, 1, 64'h0, 1,
            2, 64'h104, 1, 0, 1, 64'h0102_0304, 8'h0F);
        run("LW mis 0x101", 1, 0, 2'd2, 0, 0, 64'h101, 64'h0, 64'h0, 0, -1, 64'h0, 0,
            0, 64'h101, 0, 1, 0, 64'h0, 8'h00);
        run("LH mis 0x103", 1, 0, 2'd1, 0, 0, 64'h103, 64'h0, 64'h0, 0, -1, 64'h0, 0,
            0, 64'h103, 0, 1, 0, 64'h0, 8'h00);
        run("LD on 32", 1, 0, 2'd3, 0, 0, 64'h100, 64'h0, 64'h0, 0, -1, 64'h0, 0,
            0, 64'h100, 0, 1, 0, 64'h0, 8'h00);
        run("pass pc4", 0, 0, 2'd2, 0, 1, 64'h55, 64'h0, 64'h1004, 0, -1, 64'h0, 0,
            0, 64'h1004, 0, 0, 0, 64'h0, 8'h00);
        run("pass alu", 0, 0, 2'd2, 0, 0, 64'h55, 64'h0, 64'h1004, 0, -1, 64'h0, 0,
            0, 64'h55, 0, 0, 0, 64'h0, 8'h00);
        run("LW timeout", 1, 0, 2'd2, 0, 0, 64'h200, 64'h0, 64'h0, -1, -1, 64'h0, 0,
            5, 64'h0, 1, 0, 0, 64'h0, 8'h00);

        // A late response in IDLE must not stall or raise a bus error.
        mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222; mem_err = 1'b1;
        @(negedge clk);
        chk("late rvalid stall/valid", {62'h0, st32, mv32}, 64'h0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_err = 1'b0;
        @(negedge clk);
        chk("late rvalid exc_bus", {63'h0, eb32}, 64'h0);
        @(posedge clk); #1;

        run("SW timeout", 0, 1, 2'd2, 0, 0, 64'h208, 64'h0, 64'h0, -1, -1, 64'h0, 0,
            5, 64'h208, 1, 0, 0, 64'h0, 8'h00);
        run("LW acc timeout", 1, 0, 2'd2, 0, 0, 64'h300, 64'h0, 64'h0, 0, -1, 64'h0, 0,
            5, 64'h0, 1, 0, 1, 64'h0, 8'h0F);
        run("LW after to", 1, 0, 2'd2, 0, 0, 64'h304, 64'h0, 64'h0, 0, 1, 64'h1122_3344, 0,
            2, 64'h1122_3344, 0, 0, 1, 64'h0, 8'h0F);

        // 64-bit datapath
        sel = 1'b1;
        run("LD 0x8", 1, 0, 2'd3, 0, 0, 64'h8, 64'h0, 64'h0, 0, 2, 64'h0123_4567_89AB_CDEF, 0,
            3, 64'h0123_4567_89AB_CDEF, 0, 0, 1, 64'h0, 8'hFF);
        run("LW64 0xC", 1, 0, 2'd2, 0, 0, 64'hC, 64'h0, 64'h0, 0, 1, 64'h89AB_CDEF_0123_4567, 0,
            2, 64'hFFFF_FFFF_89AB_CDEF, 0, 0, 1, 64'h0, 8'hF0);
        run("LWU64 0xC", 1, 0, 2'd2, 1, 0, 64'hC, 64'h0, 64'h0, 0, 1, 64'h89AB_CDEF_0123_4567, 0,
            2, 64'h0000_0000_89AB_CDEF, 0, 0, 1, 64'h0, 8'hF0);
        run("SW64 0x14", 0, 1, 2'd2, 0, 0, 64'h14, 64'hFFFF_FFFF_A5A5_5A5A, 64'h0, 0, 1, 64'h0, 0,
            2, 64'h14, 0, 0, 1, 64'hA5A5_5A5A_A5A5_5A5A, 8'hF0);
        run("SB64 0x17", 0, 1, 2'd0, 0, 0, 64'h17, 64'h0000_0000_0000_003C, 64'h0, 0, 1, 64'h0, 0,
            2, 64'h17, 0, 0, 1, 64'h3C3C_3C3C_3C3C_3C3C, 8'h80);
        run("LW64 mis 0x12", 1, 0, 2'd2, 0, 0, 64'h12, 64'h0, 64'h0, 0, -1, 64'h0, 0,
            0, 64'h12, 0, 1, 0, 64'h0, 8'h00);
        run("LD mis 0x4", 1, 0, 2'd3, 0, 0, 64'h4, 64'h0, 64'h0, 0, -1, 64'h0, 0,
            0, 64'h4, 0, 1, 0, 64'h0, 8'h00);

        // Reset while waiting for the response.
        begin
            req_t r;
            r.nm = "LD reset"; r.we = 1'b0; r.a = 32'h40; r.wd = 64'h0; r.mask = 8'hFF;
            req_q.push_back(r);
        end
        op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_size = 2'd3; op_unsigned = 1'b0;
        alu_y = 64'h40; rrd2 = 64'h0; mem_ready = 1'b1;
        @(negedge clk);
        chk("LD reset issue stall", {63'h0, st64}, 64'h1);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("LD reset WAIT stall/valid", {62'h0, st64, mv64}, 64'h2);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("LD reset immediate stall/valid", {62'h0, st64, mv64}, 64'h0);
        @(posedge clk); #1;
        op_valid = 1'b0; reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD; mem_err = 1'b1;
        @(negedge clk);
        chk("post-reset rvalid", {61'h0, st64, mv64, eb64}, 64'h0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_err = 1'b0;
        run("LD after reset", 1, 0, 2'd3, 1, 0, 64'h20, 64'h0, 64'h0, 0, 1,
            64'hFEDC_BA98_7654_3210, 0, 2, 64'hFEDC_BA98_7654_3210, 0, 0, 1, 64'h0, 8'hFF);

        repeat (2) @(posedge clk);
        #1;
        chk("result queue drained", 64'(res_q.size()), 64'h0);
        chk("request queue drained", 64'(req_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
